// File: rtl/alu_arbiter_pkg.sv
// Shared types and the single-cycle operator function for alu_arbiter.
// alu_eval works on a 64-bit container and masks to the live width w (w <= 64).
package alu_arbiter_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_MOD  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_XNOR = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_SAR  = 4'd11,
    OP_RAND = 4'd12,
    OP_ROR  = 4'd13,
    OP_RXOR = 4'd14,
    OP_ILL  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIVS = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int unsigned EVAL_W = 64;

  function automatic logic [EVAL_W-1:0] alu_eval(input alu_op_e op,
                                                 input logic [EVAL_W-1:0] a,
                                                 input logic [EVAL_W-1:0] b,
                                                 input int unsigned w);
    logic [EVAL_W-1:0] mask;
    logic [EVAL_W-1:0] wv;
    logic [EVAL_W-1:0] amt;
    logic [EVAL_W-1:0] r;
    logic              sign;
    wv   = EVAL_W'(w);
    mask = (w >= EVAL_W) ? {EVAL_W{1'b1}} : ((64'd1 << w) - 64'd1);
    // Shift amount is b[log2(w):0], so it can reach 2w-1.
    amt  = b & ((wv << 1) - 64'd1);
    sign = |(a & (64'd1 << (w - 1)));
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_SHL:  r = (amt >= wv) ? '0 : (a << amt);
      OP_SHR:  r = (amt >= wv) ? '0 : (a >> amt);
      OP_SAR:  r = (amt >= wv) ? (sign ? mask : '0)
                               : ((a >> amt) | (sign ? ~(mask >> amt) : '0));
      OP_RAND: r = {{(EVAL_W-1){1'b0}}, a == mask};
      OP_ROR:  r = {{(EVAL_W-1){1'b0}}, a != '0};
      OP_RXOR: r = {{(EVAL_W-1){1'b0}}, ^a};
      default: r = '0;
    endcase
    return r & mask;
  endfunction

endpackage

// File: rtl/alu_arbiter_div.sv
// W-step restoring divider on unsigned magnitudes; one quotient bit per cycle.
// done pulses for one cycle after the last step; b == 0 yields all-ones quotient.
module alu_arbiter_div #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  quot_q, rem_q, den_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q;
  logic [W:0]    shifted;
  logic [W:0]    trial;

  assign shifted = {rem_q, quot_q[W-1]};
  assign trial   = shifted - {1'b0, den_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        quot_q <= a;
        rem_q  <= '0;
        den_q  <= b;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        // trial[W] is the borrow: set means the divisor did not fit.
        rem_q  <= trial[W] ? shifted[W-1:0] : trial[W-1:0];
        quot_q <= {quot_q[W-2:0], ~trial[W]};
        cnt_q  <= cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared integer ALU.
// Define ALU_ARBITER_DIV_EN to build the iterative divider for DIV/MOD.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [7:0]     req_op,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_err,
  output logic [1:0]     dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // rsp_valid and its payload stay put until that edge.
  state_e       state_q;
  logic         prio_q;
  alu_op_e      op_q;
  logic [W-1:0] a_q, b_q;
  logic         id_q;
  logic         rsp_valid_q, rsp_id_q, rsp_err_q;
  logic [W-1:0] rsp_data_q;

  logic [1:0]   grant;
  logic         sel_id;
  logic [3:0]   sel_op;
  logic [W-1:0] sel_a, sel_b;
  logic [W-1:0] exec_data;
  logic         exec_err;

  always_comb begin
    grant = 2'b00;
    if (!rst && state_q == ST_IDLE) begin
      if (req_valid == 2'b11) grant = prio_q ? 2'b10 : 2'b01;
      else                    grant = req_valid;
    end
  end

  assign req_ready = grant;
  assign sel_id    = grant[1];
  assign sel_op    = sel_id ? req_op[7:4]     : req_op[3:0];
  assign sel_a     = sel_id ? req_a[2*W-1:W]  : req_a[W-1:0];
  assign sel_b     = sel_id ? req_b[2*W-1:W]  : req_b[W-1:0];

  assign exec_data = W'(alu_eval(op_q, EVAL_W'(a_q), EVAL_W'(b_q), W));
  // DIV/MOD only reach EXEC when no divider is built, so they count as illegal there.
  assign exec_err  = op_q inside {OP_DIV, OP_MOD, OP_ILL};

`ifdef ALU_ARBITER_DIV_EN
  logic         sel_div, div_start, div_busy, div_done;
  logic [W-1:0] mag_a, mag_b, div_quot, div_rem, div_res;

  assign sel_div   = (sel_op == OP_DIV) || (sel_op == OP_MOD);
  assign div_start = (|grant) && sel_div;
  assign mag_a     = sel_a[W-1] ? -sel_a : sel_a;
  assign mag_b     = sel_b[W-1] ? -sel_b : sel_b;

  alu_arbiter_div #(.W(W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .a     (mag_a),
    .b     (mag_b),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot),
    .rem   (div_rem)
  );

  // Quotient sign follows the operand signs, remainder follows the dividend.
  always_comb begin
    if (b_q == '0)
      div_res = (op_q == OP_MOD) ? a_q : '1;
    else if (op_q == OP_MOD)
      div_res = a_q[W-1] ? -div_rem : div_rem;
    else
      div_res = (a_q[W-1] ^ b_q[W-1]) ? -div_quot : div_quot;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            op_q   <= alu_op_e'(sel_op);
            a_q    <= sel_a;
            b_q    <= sel_b;
            id_q   <= sel_id;
            prio_q <= ~sel_id;
`ifdef ALU_ARBITER_DIV_EN
            state_q <= sel_div ? ST_DIVS : ST_EXEC;
`else
            state_q <= ST_EXEC;
`endif
          end
        end
        ST_EXEC: begin
          rsp_data_q  <= exec_data;
          rsp_err_q   <= exec_err;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
`ifdef ALU_ARBITER_DIV_EN
        ST_DIVS: begin
          if (div_done && !div_busy) begin
            rsp_data_q  <= div_res;
            rsp_err_q   <= (b_q == '0);
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: drivers push expected {latency, id, err, data},
// a negedge monitor pops and compares on every response handshake.
module tb_alu_arbiter;

  localparam int W = 32;
`ifdef ALU_ARBITER_DIV_EN
  localparam int DLAT = W + 2;
`else
  localparam int DLAT = 2;
`endif

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         e;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     req_valid = 2'b00;
  logic [1:0]     req_ready;
  logic [7:0]     req_op = 8'd0;
  logic [2*W-1:0] req_a = '0;
  logic [2*W-1:0] req_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic           rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic [1:0]     dbg_state;

  alu_arbiter #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int             n_cmp = 0;
  int             n_err = 0;
  logic [W+9:0]   exp_q[$];
  int             acc_q[$];
  int             n_acc = 0;
  logic           seen = 1'b0;
  logic [W+1:0]   snap = '0;
  int             lat_now = 0;
  logic           prev_v = 1'b0;
  logic           prev_r = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst) begin
      seen   = 1'b0;
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (|(req_valid & req_ready)) begin
        acc_q.push_back(cyc);
        n_acc++;
      end
      if (rsp_valid) check("req_ready_while_busy", 64'(req_ready), 64'd0);
      if (prev_v && !prev_r) check("rsp_valid_held", 64'(rsp_valid), 64'd1);
      if (rsp_valid && !seen) begin
        seen    = 1'b1;
        snap    = {rsp_id, rsp_err, rsp_data};
        lat_now = (acc_q.size() != 0) ? cyc - acc_q.pop_front() : 255;
      end else if (rsp_valid) begin
        check("rsp_stable", 64'({rsp_id, rsp_err, rsp_data}), 64'(snap));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_unexpected: got id %0d data %h with nothing expected", rsp_id, rsp_data);
        end else begin
          check("rsp {lat,id,err,data}", 64'({lat_now[7:0], rsp_id, rsp_err, rsp_data}),
                64'(exp_q.pop_front()));
        end
        seen = 1'b0;
      end
      prev_v = rsp_valid;
      prev_r = rsp_ready;
    end
  end

  // drivers
  task automatic set_req(input int id, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    if (id == 0) begin
      req_op[3:0] = op;
      req_a[W-1:0] = a;
      req_b[W-1:0] = b;
    end else begin
      req_op[7:4] = op;
      req_a[2*W-1:W] = a;
      req_b[2*W-1:W] = b;
    end
    req_valid[id[0]] = 1'b1;
  endtask

  task automatic wait_accept(input int id, input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready[id[0]] && t < 100);
    if (!req_ready[id[0]]) timeout(name);
    @(posedge clk);
    #1;
    req_valid[id[0]] = 1'b0;
  endtask

  task automatic expect_rsp(input int id, input logic [W-1:0] d, input logic e, input int lat);
    exp_q.push_back({lat[7:0], id[0], e, d});
  endtask

  task automatic issue(input int id, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] d, input logic e,
                       input int lat, input string name);
    expect_rsp(id, d, e, lat);
    set_req(id, op, a, b);
    wait_accept(id, name);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      timeout(name);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp {valid,id,err,data}", 64'({rsp_valid, rsp_id, rsp_err, rsp_data}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    exp_q.delete();
    acc_q.delete();
    seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 2'b00;
    rst = 1'b0;
  endtask

  vec_t tbl [19] = '{
    '{4'd0,  32'hFFFF_FFFF, 32'd1,          32'h0000_0000, 1'b0},
    '{4'd1,  32'd0,         32'd1,          32'hFFFF_FFFF, 1'b0},
    '{4'd2,  32'd7,         32'hFFFF_FFFD,  32'hFFFF_FFEB, 1'b0},
    '{4'd5,  32'hF0F0_F0F0, 32'h3C3C_3C3C,  32'h3030_3030, 1'b0},
    '{4'd6,  32'h0F00_0000, 32'h0000_00F0,  32'h0F00_00F0, 1'b0},
    '{4'd8,  32'd0,         32'd0,          32'hFFFF_FFFF, 1'b0},
    '{4'd9,  32'd1,         32'd31,         32'h8000_0000, 1'b0},
    '{4'd9,  32'd1,         32'd32,         32'h0000_0000, 1'b0},
    '{4'd9,  32'd1,         32'd65,         32'h0000_0002, 1'b0},
    '{4'd10, 32'h8000_0000, 32'd4,          32'h0800_0000, 1'b0},
    '{4'd11, 32'h8000_0000, 32'd40,         32'hFFFF_FFFF, 1'b0},
    '{4'd11, 32'h4000_0000, 32'd33,         32'h0000_0000, 1'b0},
    '{4'd11, 32'hF000_0000, 32'd4,          32'hFF00_0000, 1'b0},
    '{4'd12, 32'hFFFF_FFFF, 32'd0,          32'h0000_0001, 1'b0},
    '{4'd12, 32'hFFFF_FFFE, 32'd0,          32'h0000_0000, 1'b0},
    '{4'd13, 32'd0,         32'd0,          32'h0000_0000, 1'b0},
    '{4'd13, 32'h0001_0000, 32'd0,          32'h0000_0001, 1'b0},
    '{4'd14, 32'd7,         32'd0,          32'h0000_0001, 1'b0},
    '{4'd15, 32'd5,         32'd6,          32'h0000_0000, 1'b1}
  };

`ifdef ALU_ARBITER_DIV_EN
  vec_t dtbl [6] = '{
    '{4'd3, 32'd10,        32'hFFFF_FFFB, 32'hFFFF_FFFE, 1'b0},
    '{4'd4, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 1'b0},
    '{4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0},
    '{4'd4, 32'd7,         32'hFFFF_FFFD, 32'h0000_0001, 1'b0},
    '{4'd3, 32'd7,         32'd0,         32'hFFFF_FFFF, 1'b1},
    '{4'd4, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 1'b1}
  };
`else
  vec_t dtbl [6] = '{
    '{4'd3, 32'd10,        32'hFFFF_FFFB, 32'd0, 1'b1},
    '{4'd4, 32'hFFFF_FFF9, 32'd3,         32'd0, 1'b1},
    '{4'd3, 32'hFFFF_FFF9, 32'd2,         32'd0, 1'b1},
    '{4'd4, 32'd7,         32'hFFFF_FFFD, 32'd0, 1'b1},
    '{4'd3, 32'd7,         32'd0,         32'd0, 1'b1},
    '{4'd4, 32'hFFFF_FFF7, 32'd0,         32'd0, 1'b1}
  };
`endif

  initial begin
    int base;
    int t;
    @(posedge clk);
    #1;
    req_valid = 2'b11;
    do_reset();

    issue(0, 4'd0, 32'd5, 32'd10, 32'd15, 1'b0, 2, "add_accept");
    drain("add_drain");

    // contention from a fresh reset: grants alternate starting at requester 0
    do_reset();
    expect_rsp(0, 32'hFFFF_FFFB, 1'b0, 2);
    expect_rsp(1, 32'hFFFF_FFFF, 1'b0, 2);
    expect_rsp(0, 32'hFFFF_FFFB, 1'b0, 2);
    base = n_acc;
    set_req(0, 4'd1, 32'd5, 32'd10);
    set_req(1, 4'd11, 32'hFFFF_FFFE, 32'd1);
    t = 0;
    while (n_acc < base + 3 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (n_acc < base + 3) timeout("rr_accepts");
    req_valid = 2'b00;
    drain("rr_drain");

    for (int i = 0; i < 19; i++) begin
      issue(i % 2, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].e, 2, "tbl_accept");
      drain("tbl_drain");
    end

    for (int i = 0; i < 6; i++) begin
      issue(i % 2, dtbl[i].op, dtbl[i].a, dtbl[i].b, dtbl[i].d, dtbl[i].e, DLAT, "div_accept");
      drain("div_drain");
    end

    // back-pressure with the other requester waiting
    rsp_ready = 1'b0;
    issue(0, 4'd7, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678, 1'b0, 2, "stall_accept");
    expect_rsp(1, 32'd5, 1'b0, 2);
    set_req(1, 4'd0, 32'd2, 32'd3);
    repeat (7) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_accept(1, "stall_next_accept");
    drain("stall_drain");

    // reset mid-operation discards it and restores priority to requester 0
    rsp_ready = 1'b0;
    set_req(0, 4'd3, 32'd100, 32'd7);
    wait_accept(0, "rst_div_accept");
    repeat (10) @(posedge clk);
    #1;
    set_req(0, 4'd0, 32'd1, 32'd2);
    set_req(1, 4'd0, 32'd7, 32'd8);
    do_reset();
    rsp_ready = 1'b1;
    expect_rsp(0, 32'd3, 1'b0, 2);
    expect_rsp(1, 32'd15, 1'b0, 2);
    set_req(0, 4'd0, 32'd1, 32'd2);
    set_req(1, 4'd0, 32'd7, 32'd8);
    wait_accept(0, "post_rst_accept0");
    wait_accept(1, "post_rst_accept1");
    drain("post_rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 2-state integer ALU between two requesters with round-robin arbitration and valid/ready handshakes. Single-cycle operators (add, sub, mul, bitwise, reductions, shifts) answer one cycle after acceptance; signed DIV/MOD run on an iterative divider for W cycles. It is the sequencing/sharing front end for the operator datapath in the formal regression designs, and is written for property checking with `always assert`.

## Interface
- W, 32, operand/result width; power of two, ≥ 8
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  request valid, bit i = requester i
- req_ready  out  2  request accepted when valid&ready
- req_op  in  2×4  opcode per requester, packed [4i+3:4i]
- req_a, req_b  in  2×W  operands per requester, packed
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&ready
- rsp_id  out  1  requester that issued the response
- rsp_data  out  W  result
- rsp_err  out  1  illegal opcode or divide by zero

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL (low W bits), 3 DIV, 4 MOD
  - 5 AND, 6 OR, 7 XOR, 8 XNOR
  - 9 SHL, 10 SHR, 11 SAR
  - 12 RED_AND, 13 RED_OR, 14 RED_XOR
  - 15 illegal → rsp_data 0, rsp_err 1
- Arithmetic is two's complement, results truncated to W. DIV truncates toward zero (10 / −5 = −2); MOD takes the sign of the dividend (−7 % 3 = −1).
- Divide by zero: DIV → all ones, MOD → dividend, rsp_err 1, still W cycles.
- Shifts use b[log2(W):0]. Amount ≥ W gives 0; SAR gives W copies of the sign bit. Reductions return the 1-bit result zero-extended.
- States:
  - IDLE: arbitrate. One grant per cycle: if both requesters are valid, the one named by pointer prio wins; otherwise the valid one wins. req_ready = grant (one-hot or zero), combinational from req_valid and prio, high only in IDLE. On acceptance, latch op, a, b and id; prio ← ~id. Single-cycle op → EXEC; DIV/MOD → DIVS.
  - EXEC: compute, register the result → RESP.
  - DIVS: step the divider once per cycle; after W steps, sign-correct → RESP.
  - RESP: rsp_valid=1; hold rsp_id/data/err stable until rsp_ready → IDLE.
- No new request is accepted while EXEC, DIVS or RESP is active.
- Reset (any state, including mid-divide): state IDLE, prio 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_err 0. The divider is cleared and the in-flight operation is discarded.

## Timing
- Accept at edge N. Single-cycle op: rsp_valid from N+2 (EXEC N+1, RESP N+2). DIV/MOD: rsp_valid from N+W+2.
- The response handshake at edge M returns to IDLE; the next acceptance is no earlier than edge M+1. Throughput is one op per 3 cycles, or W+3 cycles for DIV/MOD.
- rsp_valid never drops without rsp_ready. Outputs are registered except req_ready.

## Configuration
- ALU_ARBITER_DIV_EN defined: divider instantiated, DIV/MOD as above.
- ALU_ARBITER_DIV_EN undefined: no divider and no DIVS state. DIV/MOD behave as illegal (EXEC path, rsp_data 0, rsp_err 1, single-cycle latency).

## Structure
- alu_arbiter_pkg: opcode enum (4-bit), state enum {IDLE, EXEC, DIVS, RESP}, function alu_eval for the single-cycle ops.
- Sub-module alu_arbiter_div: W-step restoring divider on magnitudes.
  - Ports: clk, rst, start, a, b, busy, done, quot, rem.
  - Sign correction stays in the parent.

## Test plan
- Only req 0 valid, ADD 5+10, rsp_ready=1 → req_ready[0] at accept edge; rsp_valid at N+2 with rsp_data 15, rsp_id 0, rsp_err 0.
- Both valid continuously after reset, ops SUB 5−10 (req0) and SAR −2>>>1 (req1) → grants alternate 0,1,0; responses −5, −1, −5 in order.
- DIV 10/−5 and MOD −7%3 with the divider enabled → −2 and −1 at N+34 (W=32); DIV x/0 → 32'hFFFFFFFF, rsp_err 1.
- Opcode 15, and DIV without ALU_ARBITER_DIV_EN → rsp_data 0, rsp_err 1 at N+2.
- rsp_ready held low for 5 cycles → rsp_valid, rsp_data and rsp_id stable; req_ready 2'b00 throughout.
- rst asserted at DIVS step 10 → all outputs 0 immediately; a fresh ADD from req 1 then completes normally with prio reset to 0.
